// File: rtl/fsm_inv_fact.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fsm_inv_fact : largest N with N! <= X, plus exact-factorial flag
// Rev 1.0
// ----------------------------------------------------------------------------
module fsm_inv_fact #(
  parameter int WIDTH = 64,
  parameter int NW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  output logic             busy,
  output logic             done,
  output logic [NW-1:0]    n_out,
  output logic             exact
);

  localparam int CW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [NW-1:0]    k_q, k_d;
  logic [NW-1:0]    n_q, n_d;
  logic             exact_q, exact_d;

  logic [NW-1:0]    kinc;
  logic [CW-1:0]    cand;

  // Full-width product so anything past WIDTH bits still compares as "too big".
  assign kinc = k_q + NW'(1);
  assign cand = CW'(p_q) * CW'(kinc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      p_q     <= p_d;
      k_q     <= k_d;
      n_q     <= n_d;
      exact_q <= exact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    p_d     = p_q;
    k_d     = k_q;
    n_d     = n_q;
    exact_d = exact_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d = X;
          if (X == '0) begin
            n_d     = '0;
            exact_d = 1'b0;
            state_d = S_DONE;
          end else begin
            p_d     = WIDTH'(1);
            k_d     = NW'(1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (cand > CW'(x_q)) begin
          // Results land now so they are already valid in the done cycle.
          n_d     = k_q;
          exact_d = (p_q == x_q);
          state_d = S_DONE;
        end else begin
          p_d = cand[WIDTH-1:0];
          k_d = kinc;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    n_out = n_q;
    exact = exact_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fsm_inv_fact.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fsm_inv_fact : scoreboard bench for fsm_inv_fact
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fsm_inv_fact;

  localparam int WIDTH = 64;
  localparam int NW    = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] X;
  logic             busy;
  logic             done;
  logic [NW-1:0]    n_out;
  logic             exact;

  fsm_inv_fact #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .busy  (busy),
    .done  (done),
    .n_out (n_out),
    .exact (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] n;
    logic          ex;
    int            lat;
    int            c0;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      chk("done_pulse_width", 128'(prev_done), 128'(0));
      chk("busy_at_done", 128'(busy), 128'(1));
      if (q.size() == 0) begin
        chk("spurious_done", 128'(done), 128'(0));
      end else begin
        e = q.pop_front();
        chk("n_out", 128'(n_out), 128'(e.n));
        chk("exact", 128'(exact), 128'(e.ex));
        chk("latency", 128'(cyc - e.c0), 128'(e.lat));
      end
    end
    prev_done = (done === 1'b1);
  end

  // Reference: walk the factorials in 128-bit arithmetic.
  task automatic launch(input logic [WIDTH-1:0] x);
    exp_t          e;
    logic [127:0]  p;
    int            k;
    if (x == '0) begin
      e.n = '0; e.ex = 1'b0; e.lat = 1;
    end else begin
      p = 128'(1);
      k = 1;
      while (p * 128'(k + 1) <= 128'(x)) begin
        p = p * 128'(k + 1);
        k++;
      end
      e.n   = NW'(k);
      e.ex  = (p == 128'(x));
      e.lat = k + 1;
    end
    e.c0  = cyc;
    start = 1'b1;
    X     = x;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", 128'(busy), 128'(1));
  endtask

  task automatic drain_wait();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("timeout_pending", 128'(q.size()), 128'(0));
      q.delete();
    end
  endtask

  task automatic drain();
    drain_wait();
    @(negedge clk);
    chk("busy_after_done", 128'(busy), 128'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  128'(busy),  128'(0));
    chk({tag, "_done"},  128'(done),  128'(0));
    chk({tag, "_n_out"}, 128'(n_out), 128'(0));
    chk({tag, "_exact"}, 128'(exact), 128'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    X     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    launch(64'd120);                 drain();
    launch(64'd121);                 drain();
    launch(64'd119);                 drain();
    launch(64'd1);                   drain();
    launch(64'd0);                   drain();
    launch(64'd2432902008176640000); drain();
    launch(64'hFFFF_FFFF_FFFF_FFFF); drain();

    // Start while busy must be dropped.
    launch(64'd720);
    repeat (2) @(negedge clk);
    start = 1'b1;
    X     = 64'd24;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held during the done cycle must not be accepted.
    launch(64'd2);
    drain_wait();
    start = 1'b1;
    X     = 64'd5;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", 128'(busy), 128'(0));
    repeat (2) @(negedge clk);

    // Reset mid-computation aborts with no done pulse.
    launch(64'd5040);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    repeat (10) @(negedge clk);

    launch(64'd6);                   drain();

    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
